// File: rtl/time_pkg.sv
// Shared mode encodings, terminal counts and field widths for the timekeeping controller.
package time_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } mode_e;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  function automatic mode_e next_mode(input mode_e cur);
    case (cur)
      RUN:      next_mode = SET_SEC;
      SET_SEC:  next_mode = SET_MIN;
      SET_MIN:  next_mode = SET_HOUR;
      default:  next_mode = RUN;
    endcase
  endfunction

endpackage

// File: rtl/time_ctrl_mod_cnt.sv
// Modulo counter 0..MAX with synchronous clear; carry flags an increment taken at MAX.
module mod_cnt #(
  parameter int unsigned W   = 6,
  parameter int unsigned MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         carry
);

  logic [W-1:0] value_q, value_d;
  logic         at_max;

  assign at_max = (value_q == MAX[W-1:0]);

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc & at_max;

endmodule

// File: rtl/time_ctrl.sv
// Clock timekeeping: mode FSM, button edge detect, cascaded h/m/s counters.
// Define BLINK_EN to build the 0.5 Hz field-blank phase for SET modes.
//
// state    | meaning
// RUN      | time advances on tick, btn_inc ignored
// SET_SEC  | time frozen, btn_inc bumps seconds
// SET_MIN  | time frozen, btn_inc bumps minutes
// SET_HOUR | time frozen, btn_inc bumps hours
module time_ctrl
  import time_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              btn_mode,
  input  logic              btn_inc,
  output logic [SEC_W-1:0]  out_sec,
  output logic [MIN_W-1:0]  out_min,
  output logic [HOUR_W-1:0] out_hour,
  output logic [1:0]        mode,
  output logic [2:0]        blink
);

  mode_e mode_q, mode_d;
  logic  mode_hist_q, inc_hist_q;
  logic  mode_edge, inc_edge, inc_ok, run;
  logic  sec_inc, sec_clr, min_inc, hour_inc;
  logic  sec_carry, min_carry, hour_carry_unused;

  assign mode_edge = btn_mode & ~mode_hist_q;
  assign inc_edge  = btn_inc & ~inc_hist_q;
  // A mode edge swallows a coincident inc edge.
  assign inc_ok    = inc_edge & ~mode_edge;
  assign run       = (mode_q == RUN);
  assign mode_d    = mode_edge ? next_mode(mode_q) : mode_q;

  assign sec_clr  = run & mode_edge;
  assign sec_inc  = run ? (tick & ~mode_edge) : ((mode_q == SET_SEC) & inc_ok);
  assign min_inc  = run ? sec_carry : ((mode_q == SET_MIN) & inc_ok);
  assign hour_inc = run ? min_carry : ((mode_q == SET_HOUR) & inc_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= RUN;
      mode_hist_q <= 1'b1;
      inc_hist_q  <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      mode_hist_q <= btn_mode;
      inc_hist_q  <= btn_inc;
    end
  end

  mod_cnt #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst_n(rst_n), .inc(sec_inc), .clr(sec_clr),
    .value(out_sec), .carry(sec_carry)
  );

  mod_cnt #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .rst_n(rst_n), .inc(min_inc), .clr(1'b0),
    .value(out_min), .carry(min_carry)
  );

  mod_cnt #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk(clk), .rst_n(rst_n), .inc(hour_inc), .clr(1'b0),
    .value(out_hour), .carry(hour_carry_unused)
  );

  assign mode = mode_q;

`ifdef BLINK_EN
  logic       phase_q, phase_d;
  logic [2:0] blink_q, blink_d;

  always_comb begin
    phase_d = (mode_d == RUN) ? 1'b0 : (phase_q ^ tick);
    blink_d = 3'b000;
    if (phase_d) begin
      case (mode_d)
        SET_SEC:  blink_d = 3'b001;
        SET_MIN:  blink_d = 3'b010;
        SET_HOUR: blink_d = 3'b100;
        default:  blink_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      blink_q <= 3'b000;
    end else begin
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 3'b000;
`endif

endmodule

// File: tb/tb_time_ctrl.sv
// Directed bench for time_ctrl: reset, preload/rollover, SET freezing, wraps, blink.
module tb_time_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, btn_mode, btn_inc;
  logic [5:0] out_sec, out_min;
  logic [4:0] out_hour;
  logic [1:0] mode;
  logic [2:0] blink;

  int checks = 0;
  int errors = 0;

  time_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .out_sec(out_sec), .out_min(out_min), .out_hour(out_hour), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1; step(1); tick = 1'b0;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step(1); btn_mode = 1'b0; step(1);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1; step(1); btn_inc = 1'b0; step(1);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, int'(out_hour), h);
    chk({tag, "_min"},  int'(out_min),  m);
    chk({tag, "_sec"},  int'(out_sec),  s);
  endtask

  function automatic int exp_blink(input int field_bit, input bit ph);
`ifdef BLINK_EN
    return ph ? field_bit : 0;
`else
    return 0;
`endif
  endfunction

  initial begin
    rst_n = 1'b0; tick = 1'b0; btn_mode = 1'b1; btn_inc = 1'b0;
    step(2);
    chk_time("rst", 0, 0, 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_blink", int'(blink), 0);
    rst_n = 1'b1;
    step(3);
    chk("held_mode", int'(mode), 0);
    btn_mode = 1'b0;
    step(1);
    chk_time("held", 0, 0, 0);

    // Preload 23:59:58 through the SET modes.
    press_mode();
    chk("enter_set_sec", int'(mode), 1);
    press_inc(58);
    chk("set_sec58", int'(out_sec), 58);
    press_mode();
    chk("enter_set_min", int'(mode), 2);
    press_inc(59);
    chk("set_min59", int'(out_min), 59);
    press_mode();
    chk("enter_set_hour", int'(mode), 3);
    press_inc(23);
    press_mode();
    chk("back_run", int'(mode), 0);
    chk_time("preload", 23, 59, 58);

    do_tick();
    chk_time("tick1", 23, 59, 59);
    do_tick();
    chk_time("rollover", 0, 0, 0);

    for (int i = 0; i < 10; i++) do_tick();
    chk_time("ten_sec", 0, 0, 10);

    // RUN -> SET_SEC clears seconds; ticks then frozen. Phase toggles 5 times.
    press_mode();
    chk("set_sec_mode", int'(mode), 1);
    chk("set_sec_clear", int'(out_sec), 0);
    for (int i = 0; i < 5; i++) do_tick();
    chk("frozen_sec", int'(out_sec), 0);
    chk("blink_sec_ph1", int'(blink), exp_blink(1, 1'b1));

    press_inc(3);
    chk("sec_inc3", int'(out_sec), 3);
    btn_mode = 1'b1; btn_inc = 1'b1; step(1);
    btn_mode = 1'b0; btn_inc = 1'b0; step(1);
    chk("both_mode", int'(mode), 2);
    chk("both_sec", int'(out_sec), 3);

    // Extra tick in SET_MIN brings the phase back to 0.
    do_tick();
    chk("frozen_min", int'(out_min), 0);
    press_inc(59);
    chk("min59", int'(out_min), 59);
    press_inc(1);
    chk("min_wrap", int'(out_min), 0);
    chk("min_wrap_hour", int'(out_hour), 0);

    press_mode();
    chk("set_hour_mode", int'(mode), 3);
    chk("blink_hour_start", int'(blink), 0);
    do_tick(); chk("blink_t1", int'(blink), exp_blink(4, 1'b1));
    do_tick(); chk("blink_t2", int'(blink), exp_blink(4, 1'b0));
    do_tick(); chk("blink_t3", int'(blink), exp_blink(4, 1'b1));
    do_tick(); chk("blink_t4", int'(blink), exp_blink(4, 1'b0));
    chk("frozen_hour", int'(out_hour), 0);
    press_inc(25);
    chk("hour_wrap", int'(out_hour), 1);
    chk("hour_wrap_min", int'(out_min), 0);

    do_tick();
    // Tick coincident with SET_HOUR -> RUN must not count.
    btn_mode = 1'b1; tick = 1'b1; step(1);
    btn_mode = 1'b0; tick = 1'b0;
    chk("exit_mode", int'(mode), 0);
    chk("exit_blink", int'(blink), 0);
    chk_time("exit", 1, 0, 3);
    step(1);
    do_tick();
    chk_time("resume", 1, 0, 4);

    // Tick coincident with RUN -> SET_SEC is dropped; seconds cleared.
    btn_mode = 1'b1; tick = 1'b1; step(1);
    btn_mode = 1'b0; tick = 1'b0;
    chk("drop_mode", int'(mode), 1);
    chk_time("drop", 1, 0, 0);
    press_inc(7);

    rst_n = 1'b0; step(1);
    chk_time("midrst", 0, 0, 0);
    chk("midrst_mode", int'(mode), 0);
    chk("midrst_blink", int'(blink), 0);
    rst_n = 1'b1; step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
